spike_pattern_decoder: RTL and testbench
========================================

// Module: spike_pattern_decoder
// PURPOSE
//   Readout end of the Hopfield recall path: watches the N neuron spike lines, counts spike onsets per neuron over
//   fixed windows of WINDOW clocks and thresholds the counts into a recalled N-bit pattern.
//   Each pattern is offered downstream on a valid/ready handshake.
//   Flags convergence when the recalled pattern is identical for STABLE_WINDOWS consecutive windows.
// PARAMETERS
//   N              7    number of neurons / spike inputs
//   WINDOW         256  sampled clock cycles per decode window (>=2)
//   CNT_W          8    per-neuron onset counter width, saturating
//   THRESH         4    onsets needed in a window for recalled bit = 1 (1..2^CNT_W-1)
//   STABLE_WINDOWS 3    consecutive identical nonzero windows that assert converged (>=2)
// PORTS
//   clk              in   1  system clock
//   reset_n          in   1  synchronous, active-low reset
//   enable           in   1  1 = decode windows back-to-back; 0 = abort/idle
//   spikes           in   N  raw spike outputs of the neuron array
//   recalled_pattern out  N  decoded pattern, stable while recalled_valid=1
//   recalled_valid   out  1  pattern available
//   recalled_ready   in   1  consumer accepts when valid&&ready at clk edge
//   converged        out  1  last STABLE_WINDOWS patterns equal and nonzero
//   overrun          out  1  sticky: a window result was dropped due to backpressure
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; counters, window counter, prev_spikes, stable count cleared.
//   Onset: edge[i] = spikes[i] & ~prev_spikes[i]; prev_spikes registered every cycle (also in IDLE).
//   Holding a spike line high counts once.
//   FSM IDLE: counters held at 0; enable=1 -> COUNT next cycle.
//   The first COUNT cycle is sample 0.
//   FSM COUNT: each cycle cnt[i] += edge[i], saturating at 2^CNT_W-1; win_cnt increments 0..WINDOW-1.
//   Window end (win_cnt==WINDOW-1): new[i] = (cnt[i]+edge[i]) >= THRESH, computed CNT_W+1 bits wide.
//   The final sample is included.
//   Next cycle: cnt=0, win_cnt=0, remain COUNT.
//   Result latency: recalled_valid rises on the clock edge ending sample WINDOW-1.
//   Handshake: valid stays 1 with a stable pattern until valid&&ready, then drops next edge.
//   When a window ends while valid=1 and ready=0: keep the old pattern, drop the new one, set overrun.
//   Window ends in the same cycle as an accept (valid&&ready): the new pattern loads and valid stays 1.
//   No drop occurs in that case.
//   Convergence: compare every completed window, dropped or not, to prev_result.
//     Equal and nonzero: stable_cnt++ (saturate at STABLE_WINDOWS-1). Otherwise: stable_cnt=0.
//     converged = (stable_cnt==STABLE_WINDOWS-1); registered, updates with the window-end edge.
//   enable=0 in COUNT: next cycle IDLE.
//     The partial window is discarded with no output.
//     cnt, win_cnt, stable_cnt and converged are cleared.
//     A pending valid pattern is kept until accepted.
//     overrun is cleared.
//   reset_n=0 at any time, including mid-window or mid-handshake, clears everything on that clock edge.
// TESTING
//   Reset: hold reset_n=0 with spikes toggling -> all outputs 0, no valid after release with enable=0.
//   Decode (WINDOW=16,THRESH=3): neuron0 3 onsets, neuron1 2, neuron6 4 -> pattern 7'b1000001, valid at clk 16.
//   Held-high: spikes[2]=1 for 10 cycles, THRESH=1 -> counts 1 -> bit2=1.
//   Held-high with THRESH=2 -> bit2=0.
//   Backpressure: ready=0 over 2 windows -> first pattern held, overrun=1 after 2nd window end; ready=1 -> valid drops.
//   Convergence: same pattern 7'b0000101 for 3 windows -> converged=1 with 3rd valid.
//   A differing 4th window drops converged.
//   An all-zero pattern never sets converged.
//   Abort: enable low at sample 8, high again -> no output for the aborted window.
//   The next valid arrives 16 samples after re-entering COUNT.
//   reset_n low mid-window clears counters.

Source files
------------

// File: rtl/spike_pattern_decoder_if.sv
// Handshake/bus bundle between the spike pattern decoder and its environment.
interface spike_pattern_decoder_if #(
  parameter int unsigned N = 7
);
  logic         enable;
  logic [N-1:0] spikes;
  logic [N-1:0] recalled_pattern;
  logic         recalled_valid;
  logic         recalled_ready;
  logic         converged;
  logic         overrun;

  modport master (
    input  enable, spikes, recalled_ready,
    output recalled_pattern, recalled_valid, converged, overrun
  );

  modport slave (
    output enable, spikes, recalled_ready,
    input  recalled_pattern, recalled_valid, converged, overrun
  );
endinterface

// File: rtl/spike_pattern_decoder.sv
// Counts spike onsets per neuron over fixed windows, thresholds them into a recalled
// pattern offered on valid/ready, and flags convergence over repeated identical windows.
module spike_pattern_decoder #(
  parameter int unsigned N              = 7,
  parameter int unsigned WINDOW         = 256,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned THRESH         = 4,
  parameter int unsigned STABLE_WINDOWS = 3
) (
  input logic                clk,
  input logic                reset_n,
  spike_pattern_decoder_if.master bus
);

  localparam int unsigned WIN_W = $clog2(WINDOW);
  localparam int unsigned STB_W = $clog2(STABLE_WINDOWS);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_WINDOWS - 1);
  localparam logic [CNT_W:0]   THRESH_V = (CNT_W + 1)'(THRESH);

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t                    r_state;
  logic [N-1:0]              r_prev_spikes;
  logic [N-1:0][CNT_W-1:0]   r_cnt;
  logic [WIN_W-1:0]          r_win_cnt;
  logic [STB_W-1:0]          r_stable;
  logic [N-1:0]              r_prev_result;
  logic [N-1:0]              r_pattern;
  logic                      r_valid;
  logic                      r_converged;
  logic                      r_overrun;

  logic [N-1:0]              w_edge;
  logic [N-1:0]              w_new;
  logic [N-1:0][CNT_W-1:0]   w_cnt_inc;
  logic                      w_win_end;
  logic                      w_accept;
  logic                      w_match;
  logic [STB_W-1:0]          w_stable_nxt;

  // Onset detection, saturating increment and end-of-window threshold (final sample included)
  always_comb begin
    w_edge    = bus.spikes & ~r_prev_spikes;
    w_new     = '0;
    w_cnt_inc = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_new[i]     = ({1'b0, r_cnt[i]} + {{CNT_W{1'b0}}, w_edge[i]}) >= THRESH_V;
      w_cnt_inc[i] = (r_cnt[i] == CNT_MAX) ? r_cnt[i] : r_cnt[i] + CNT_W'(w_edge[i]);
    end
  end

  assign w_win_end    = (r_state == S_COUNT) && (r_win_cnt == WIN_LAST);
  assign w_accept     = r_valid && bus.recalled_ready;
  assign w_match      = (w_new == r_prev_result) && (|w_new);
  assign w_stable_nxt = !w_match ? '0 :
                        (r_stable == STB_MAX) ? r_stable : r_stable + STB_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_prev_spikes <= '0;
      r_cnt         <= '0;
      r_win_cnt     <= '0;
      r_stable      <= '0;
      r_prev_result <= '0;
      r_pattern     <= '0;
      r_valid       <= 1'b0;
      r_converged   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_prev_spikes <= bus.spikes;
      if (w_accept) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_win_cnt <= '0;
          if (bus.enable) r_state <= S_COUNT;
        end
        S_COUNT: begin
          if (!bus.enable) begin
            // Abort: discard partial window, keep any pending pattern
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_win_cnt   <= '0;
            r_stable    <= '0;
            r_converged <= 1'b0;
            r_overrun   <= 1'b0;
          end else if (w_win_end) begin
            r_cnt         <= '0;
            r_win_cnt     <= '0;
            r_prev_result <= w_new;
            r_stable      <= w_stable_nxt;
            r_converged   <= (w_stable_nxt == STB_MAX);
            // A slot frees up either when empty or when accepted on this same edge
            if (!r_valid || w_accept) begin
              r_pattern <= w_new;
              r_valid   <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_cnt     <= w_cnt_inc;
            r_win_cnt <= r_win_cnt + WIN_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.recalled_pattern = r_pattern;
  assign bus.recalled_valid   = r_valid;
  assign bus.converged        = r_converged;
  assign bus.overrun          = r_overrun;

endmodule

// File: tb/tb_spike_pattern_decoder.sv
// Directed bench: three decoders (THRESH 3/1/2, WINDOW 16) share one stimulus stream.
module tb_spike_pattern_decoder;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       ready;
  logic [6:0] spikes;
  int         tests_run;
  int         tests_failed;

  spike_pattern_decoder_if #(.N(7)) bus3 ();
  spike_pattern_decoder_if #(.N(7)) bus1 ();
  spike_pattern_decoder_if #(.N(7)) bus2 ();

  assign bus3.enable = enable;  assign bus3.spikes = spikes;  assign bus3.recalled_ready = ready;
  assign bus1.enable = enable;  assign bus1.spikes = spikes;  assign bus1.recalled_ready = ready;
  assign bus2.enable = enable;  assign bus2.spikes = spikes;  assign bus2.recalled_ready = ready;

  spike_pattern_decoder #(.N(7), .WINDOW(16), .CNT_W(8), .THRESH(3), .STABLE_WINDOWS(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3));
  spike_pattern_decoder #(.N(7), .WINDOW(16), .CNT_W(8), .THRESH(1), .STABLE_WINDOWS(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));
  spike_pattern_decoder #(.N(7), .WINDOW(16), .CNT_W(8), .THRESH(2), .STABLE_WINDOWS(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; enable = 1'b0; ready = 1'b0; spikes = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic start_count();
    enable = 1'b1; spikes = '0;
    tick();
  endtask

  // Drives samples first..first+count-1; mask lines pulse on even samples below 2*onsets
  task automatic run_samples(input logic [6:0] mask, input int onsets, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      spikes = ((k % 2 == 0) && (k < 2 * onsets)) ? mask : 7'd0;
      tick();
    end
    spikes = '0;
  endtask

  task automatic test_reset();
    logic seen_valid;
    reset_n = 1'b0; enable = 1'b0; ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      spikes = (i % 2 == 1) ? 7'h55 : 7'h2A;
      tick();
    end
    tests_run++;
    if ({bus3.recalled_pattern, bus3.recalled_valid, bus3.converged, bus3.overrun} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs_t3: got %b expected 0",
               {bus3.recalled_pattern, bus3.recalled_valid, bus3.converged, bus3.overrun});
    end
    tests_run++;
    if ({bus1.recalled_pattern, bus1.recalled_valid, bus1.converged, bus1.overrun} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs_t1: got %b expected 0",
               {bus1.recalled_pattern, bus1.recalled_valid, bus1.converged, bus1.overrun});
    end
    reset_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      spikes = (i % 2 == 1) ? 7'h7F : 7'h00;
      tick();
      seen_valid = seen_valid | bus3.recalled_valid | bus1.recalled_valid;
    end
    spikes = '0;
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_no_valid: got %b expected 0", seen_valid);
    end
  endtask

  task automatic test_decode();
    logic [6:0] v;
    apply_reset();
    start_count();
    for (int k = 0; k < 16; k++) begin
      v = '0;
      if (k == 2 || k == 4 || k == 15) v[0] = 1'b1;
      if (k == 1 || k == 3) v[1] = 1'b1;
      if (k == 5 || k == 7 || k == 9 || k == 11) v[6] = 1'b1;
      spikes = v;
      if (k == 15) begin
        tests_run++;
        if (bus3.recalled_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL decode_early_valid: got %b expected 0", bus3.recalled_valid);
        end
      end
      tick();
    end
    spikes = '0;
    tests_run++;
    if ({bus3.recalled_valid, bus3.recalled_pattern} !== {1'b1, 7'b1000001}) begin
      tests_failed++;
      $display("FAIL decode_t3: got v=%b p=%b expected v=1 p=1000001", bus3.recalled_valid, bus3.recalled_pattern);
    end
    tests_run++;
    if (bus1.recalled_pattern !== 7'b1000011) begin
      tests_failed++;
      $display("FAIL decode_t1: got %b expected 1000011", bus1.recalled_pattern);
    end
    tests_run++;
    if (bus2.recalled_pattern !== 7'b1000011) begin
      tests_failed++;
      $display("FAIL decode_t2: got %b expected 1000011", bus2.recalled_pattern);
    end
    ready = 1'b1;
    tick();
    tests_run++;
    if (bus3.recalled_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL decode_accept_drop: got %b expected 0", bus3.recalled_valid);
    end
  endtask

  task automatic test_held_high();
    apply_reset();
    start_count();
    for (int k = 0; k < 16; k++) begin
      spikes = (k < 10) ? 7'b0000100 : 7'b0000000;
      tick();
    end
    spikes = '0;
    tests_run++;
    if ({bus1.recalled_valid, bus1.recalled_pattern} !== {1'b1, 7'b0000100}) begin
      tests_failed++;
      $display("FAIL held_t1: got v=%b p=%b expected v=1 p=0000100", bus1.recalled_valid, bus1.recalled_pattern);
    end
    tests_run++;
    if ({bus2.recalled_valid, bus2.recalled_pattern} !== {1'b1, 7'b0000000}) begin
      tests_failed++;
      $display("FAIL held_t2: got v=%b p=%b expected v=1 p=0000000", bus2.recalled_valid, bus2.recalled_pattern);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    start_count();
    run_samples(7'b0000001, 3, 0, 16);
    tests_run++;
    if ({bus3.recalled_valid, bus3.recalled_pattern, bus3.overrun} !== {1'b1, 7'b0000001, 1'b0}) begin
      tests_failed++;
      $display("FAIL bp_first: got v=%b p=%b o=%b expected v=1 p=0000001 o=0",
               bus3.recalled_valid, bus3.recalled_pattern, bus3.overrun);
    end
    run_samples(7'b0000010, 3, 0, 16);
    tests_run++;
    if ({bus3.recalled_valid, bus3.recalled_pattern, bus3.overrun} !== {1'b1, 7'b0000001, 1'b1}) begin
      tests_failed++;
      $display("FAIL bp_hold_overrun: got v=%b p=%b o=%b expected v=1 p=0000001 o=1",
               bus3.recalled_valid, bus3.recalled_pattern, bus3.overrun);
    end
    ready = 1'b1;
    tick();
    tests_run++;
    if ({bus3.recalled_valid, bus3.overrun} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_release: got v=%b o=%b expected v=0 o=1", bus3.recalled_valid, bus3.overrun);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    start_count();
    run_samples(7'b0000001, 3, 0, 16);
    run_samples(7'b0000010, 3, 0, 15);
    ready = 1'b1;
    run_samples(7'b0000010, 3, 15, 1);
    tests_run++;
    if ({bus3.recalled_valid, bus3.recalled_pattern, bus3.overrun} !== {1'b1, 7'b0000010, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_load: got v=%b p=%b o=%b expected v=1 p=0000010 o=0",
               bus3.recalled_valid, bus3.recalled_pattern, bus3.overrun);
    end
    tick();
    tests_run++;
    if (bus3.recalled_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: got %b expected 0", bus3.recalled_valid);
    end
  endtask

  task automatic test_convergence();
    apply_reset();
    ready = 1'b1;
    start_count();
    run_samples(7'b0000101, 3, 0, 16);
    run_samples(7'b0000101, 3, 0, 16);
    tests_run++;
    if (bus3.converged !== 1'b0) begin
      tests_failed++;
      $display("FAIL conv_two_windows: got %b expected 0", bus3.converged);
    end
    run_samples(7'b0000101, 3, 0, 16);
    tests_run++;
    if ({bus3.converged, bus3.recalled_valid, bus3.recalled_pattern} !== {1'b1, 1'b1, 7'b0000101}) begin
      tests_failed++;
      $display("FAIL conv_third: got c=%b v=%b p=%b expected c=1 v=1 p=0000101",
               bus3.converged, bus3.recalled_valid, bus3.recalled_pattern);
    end
    run_samples(7'b0000001, 3, 0, 16);
    tests_run++;
    if (bus3.converged !== 1'b0) begin
      tests_failed++;
      $display("FAIL conv_differs: got %b expected 0", bus3.converged);
    end
    apply_reset();
    ready = 1'b1;
    start_count();
    for (int w = 0; w < 4; w++) begin
      run_samples(7'b0000000, 0, 0, 16);
      if (w >= 2) begin
        tests_run++;
        if ({bus3.converged, bus3.recalled_valid, bus3.recalled_pattern} !== {1'b0, 1'b1, 7'b0000000}) begin
          tests_failed++;
          $display("FAIL conv_zero_w%0d: got c=%b v=%b p=%b expected c=0 v=1 p=0000000",
                   w, bus3.converged, bus3.recalled_valid, bus3.recalled_pattern);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic seen_valid;
    apply_reset();
    start_count();
    run_samples(7'b0000001, 3, 0, 8);
    enable = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen_valid = seen_valid | bus3.recalled_valid;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_output: got %b expected 0", seen_valid);
    end
    start_count();
    run_samples(7'b0000010, 3, 0, 15);
    tests_run++;
    if (bus3.recalled_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_early_valid: got %b expected 0", bus3.recalled_valid);
    end
    run_samples(7'b0000010, 3, 15, 1);
    tests_run++;
    if ({bus3.recalled_valid, bus3.recalled_pattern} !== {1'b1, 7'b0000010}) begin
      tests_failed++;
      $display("FAIL abort_next_window: got v=%b p=%b expected v=1 p=0000010",
               bus3.recalled_valid, bus3.recalled_pattern);
    end
    // Abort with a pending pattern and overrun set
    apply_reset();
    start_count();
    run_samples(7'b0000001, 3, 0, 16);
    run_samples(7'b0000010, 3, 0, 16);
    enable = 1'b0;
    tick(); tick();
    tests_run++;
    if ({bus3.recalled_valid, bus3.recalled_pattern, bus3.overrun} !== {1'b1, 7'b0000001, 1'b0}) begin
      tests_failed++;
      $display("FAIL abort_pending: got v=%b p=%b o=%b expected v=1 p=0000001 o=0",
               bus3.recalled_valid, bus3.recalled_pattern, bus3.overrun);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start_count();
    run_samples(7'b0000001, 3, 0, 16);
    run_samples(7'b0000001, 3, 0, 8);
    reset_n = 1'b0;
    tick();
    tests_run++;
    if ({bus3.recalled_valid, bus3.recalled_pattern, bus1.recalled_valid} !== 9'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: got v3=%b p3=%b v1=%b expected all 0",
               bus3.recalled_valid, bus3.recalled_pattern, bus1.recalled_valid);
    end
    reset_n = 1'b1;
    tick();
    run_samples(7'b0000001, 1, 0, 15);
    tests_run++;
    if (bus3.recalled_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_early_valid: got %b expected 0", bus3.recalled_valid);
    end
    run_samples(7'b0000001, 1, 15, 1);
    tests_run++;
    if ({bus3.recalled_valid, bus3.recalled_pattern} !== {1'b1, 7'b0000000}) begin
      tests_failed++;
      $display("FAIL rst_mid_t3: got v=%b p=%b expected v=1 p=0000000",
               bus3.recalled_valid, bus3.recalled_pattern);
    end
    tests_run++;
    if (bus1.recalled_pattern !== 7'b0000001) begin
      tests_failed++;
      $display("FAIL rst_mid_t1: got %b expected 0000001", bus1.recalled_pattern);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset_n = 1'b0; enable = 1'b0; ready = 1'b0; spikes = '0;
    test_reset();
    test_decode();
    test_held_high();
    test_backpressure();
    test_back_to_back();
    test_convergence();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
